// File: rtl/spi_bus_arbiter.sv
// SPI bus arbiter: two requesters (RTC engine, cartridge SPI master) share one
// SPI pad set. Round-robin grant, guard gap with chip select high between
// ownerships, and revocation of an owner that stalls the MCU for too long.
module spi_bus_arbiter #(
   parameter int unsigned GUARD_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       SClk_i,
   input  logic       Reset_i,
   input  logic [1:0] Req_i,
   input  logic [1:0] Release_i,
   input  logic [1:0] ReqDo_i,
   input  logic [1:0] ReqnSel_i,
   input  logic [1:0] ReqClkRunning_i,
   input  logic [1:0] ReqClkStretch_i,
   input  logic       MCUReadyFallingEdge_i,
   output logic [1:0] Gnt_o,
   output logic       SPIDo_o,
   output logic       nMCUSel_o,
   output logic       SPIClkRunning_o,
   output logic       SPIClkStretch_o,
   output logic       Busy_o,
   output logic       TimeoutEvt_o
);

   typedef enum logic [1:0] {IDLE, OWN, GUARD} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  GD_LAST = 4'(GUARD_CYCLES - 1);

   state_t      state_q;
   logic [1:0]  gnt_q;
   logic        tevt_q;
   logic [15:0] tcnt_q;
   logic [3:0]  gcnt_q;
   logic [1:0]  mask_q;
   logic        last_q;
   logic        owner_q;

   logic [1:0]  elig;
   logic        win_d;
   logic        own_end;
   logic        timeout_hit;
   logic [1:0]  mask_d;

   // Grant selection, end-of-ownership detection and mask next state
   always_comb begin
      elig        = Req_i & ~mask_q;
      // On a tie the requester that did not own last wins; otherwise the only one asking
      win_d       = (elig == 2'b11) ? ~last_q : elig[1];
      own_end     = Release_i[owner_q] | ~Req_i[owner_q];
      // A release or request drop on the threshold cycle is a normal release, not a timeout
      timeout_hit = (state_q == OWN) && !own_end && !MCUReadyFallingEdge_i &&
                    (tcnt_q == TO_LAST);
      // Mask clears as soon as the requester lets go of Req; set on revocation
      mask_d      = mask_q & Req_i;
      if (timeout_hit) mask_d[owner_q] = 1'b1;
   end

   // Arbiter state machine with registered grant and timeout pulse
   always_ff @(posedge SClk_i) begin
      if (Reset_i) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         tevt_q  <= 1'b0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         mask_q  <= 2'b00;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
      end else begin
         tevt_q <= 1'b0;
         mask_q <= mask_d;
         case (state_q)
            IDLE: begin
               if (|elig) begin
                  state_q <= OWN;
                  owner_q <= win_d;
                  last_q  <= win_d;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
                  tcnt_q  <= '0;
               end
            end
            OWN: begin
               if (own_end || timeout_hit) begin
                  state_q <= GUARD;
                  gnt_q   <= 2'b00;
                  gcnt_q  <= '0;
                  tevt_q  <= timeout_hit;
               end else if (MCUReadyFallingEdge_i) begin
                  tcnt_q <= '0;
               end else begin
                  tcnt_q <= tcnt_q + 16'd1;
               end
            end
            GUARD: begin
               if (gcnt_q == GD_LAST) state_q <= IDLE;
               else                   gcnt_q  <= gcnt_q + 4'd1;
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 2'b00;
            end
         endcase
      end
   end

   // Pad mux: owner drives the bus in OWN, idle-bus values otherwise
   always_comb begin
      if (state_q == OWN) begin
         SPIDo_o         = ReqDo_i[owner_q];
         nMCUSel_o       = ReqnSel_i[owner_q];
         SPIClkRunning_o = ReqClkRunning_i[owner_q];
         SPIClkStretch_o = ReqClkStretch_i[owner_q];
      end else begin
         SPIDo_o         = 1'b1;
         nMCUSel_o       = 1'b1;
         SPIClkRunning_o = 1'b0;
         SPIClkStretch_o = 1'b0;
      end
   end

   assign Gnt_o        = gnt_q;
   assign TimeoutEvt_o = tevt_q;
   assign Busy_o       = (state_q != IDLE) || (Req_i != 2'b00);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios plus a random
// run compared cycle by cycle against a behavioural ownership model.
module tb_spi_bus_arbiter;

   localparam int G = 4;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req, rel, rdo, rnsel, rrun, rstr;
   logic       mcu;
   logic [1:0] gnt;
   logic       sdo, nsel, run, str, busy, tevt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // behavioural model: who owns the bus, guard cycles left, stall time, masks
   int         m_own   = -1;
   int         m_guard = 0;
   int         m_timer = 0;
   int         m_last  = 1;
   logic [1:0] m_mask  = 2'b00;
   logic       m_tevt  = 1'b0;

   always #5 clk = ~clk;

   spi_bus_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
      .SClk_i(clk), .Reset_i(rst), .Req_i(req), .Release_i(rel),
      .ReqDo_i(rdo), .ReqnSel_i(rnsel), .ReqClkRunning_i(rrun),
      .ReqClkStretch_i(rstr), .MCUReadyFallingEdge_i(mcu),
      .Gnt_o(gnt), .SPIDo_o(sdo), .nMCUSel_o(nsel), .SPIClkRunning_o(run),
      .SPIClkStretch_o(str), .Busy_o(busy), .TimeoutEvt_o(tevt));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   task automatic model_step();
      bit e0, e1;
      int pick;
      if (rst) begin
         m_own = -1; m_guard = 0; m_timer = 0; m_mask = 2'b00; m_last = 1; m_tevt = 1'b0;
         return;
      end
      m_tevt = 1'b0;
      if (m_own >= 0) begin
         if (rel[m_own] || !req[m_own]) begin
            m_own = -1; m_guard = G;
         end else if (mcu) begin
            m_timer = 0;
         end else if (m_timer == T - 1) begin
            m_mask[m_own] = 1'b1; m_tevt = 1'b1; m_own = -1; m_guard = G;
         end else begin
            m_timer++;
         end
      end else if (m_guard > 0) begin
         m_guard--;
      end else begin
         e0 = req[0] && !m_mask[0];
         e1 = req[1] && !m_mask[1];
         pick = -1;
         if (e0 && e1) pick = 1 - m_last;
         else if (e0)  pick = 0;
         else if (e1)  pick = 1;
         if (pick >= 0) begin
            m_own = pick; m_last = pick; m_timer = 0;
         end
      end
      for (int i = 0; i < 2; i++) if (!req[i]) m_mask[i] = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 2'b00; rel = 2'b00; mcu = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b00; rel = 2'b00; mcu = 1'b0;
      rdo = 2'b00; rnsel = 2'b00; rrun = 2'b11; rstr = 2'b11;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else pass_cnt++;
      total_cnt++; if ({sdo, nsel, run, str} !== 4'b1100)
         $display("FAIL reset_bus: got %b want 1100", {sdo, nsel, run, str}); else pass_cnt++;
      total_cnt++; if ({busy, tevt} !== 2'b00)
         $display("FAIL reset_busy_tevt: got %b want 00", {busy, tevt}); else pass_cnt++;
   endtask

   task automatic test_basic();
      do_reset();
      req = 2'b01; rnsel = 2'b10; rdo = 2'b10; rrun = 2'b00; rstr = 2'b00;
      tick();
      @(negedge clk);
      total_cnt++; if (gnt !== 2'b01) $display("FAIL basic_grant: got %b want 01", gnt); else pass_cnt++;
      total_cnt++; if ({nsel, sdo} !== 2'b00) $display("FAIL basic_follow: got %b want 00", {nsel, sdo}); else pass_cnt++;
      rdo = 2'b01; rnsel = 2'b00; rrun = 2'b10; rstr = 2'b01;
      #1;
      total_cnt++; if ({sdo, nsel, run, str} !== 4'b1001)
         $display("FAIL basic_owner_only: got %b want 1001", {sdo, nsel, run, str}); else pass_cnt++;
      for (int i = 2; i <= 10; i++) tick();
      rel = 2'b01;
      tick();
      rel = 2'b00; req = 2'b00;
      @(negedge clk);
      total_cnt++; if ({gnt, nsel} !== 3'b001) $display("FAIL basic_release: got %b want 001", {gnt, nsel}); else pass_cnt++;
      tick(); tick(); tick();
      @(negedge clk);
      total_cnt++; if (busy !== 1'b1) $display("FAIL basic_guard_busy: got %b want 1", busy); else pass_cnt++;
      tick();
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_at_15: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int  k;
      bit  got;
      do_reset();
      rnsel = 2'b00; rdo = 2'b00; rrun = 2'b00; rstr = 2'b00; req = 2'b11;
      tick();
      @(negedge clk);
      total_cnt++; if (gnt !== 2'b01) $display("FAIL rr_first: got %b want 01", gnt); else pass_cnt++;
      rel = 2'b01; tick(); rel = 2'b00;
      k = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (gnt !== 2'b00) got = 1;
         else begin
            if (nsel) k++;
            tick();
         end
      end
      total_cnt++; if (gnt !== 2'b10) $display("FAIL rr_second: got %b want 10", gnt); else pass_cnt++;
      total_cnt++; if (k != G + 1) $display("FAIL rr_spacing: got %0d want %0d", k, G + 1); else pass_cnt++;
      rel = 2'b10; tick(); rel = 2'b00;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (gnt !== 2'b00) got = 1; else tick();
      end
      total_cnt++; if (gnt !== 2'b01) $display("FAIL rr_third: got %b want 01", gnt); else pass_cnt++;
   endtask

   task automatic test_timeout();
      bit early, regrant, got;
      do_reset();
      rnsel = 2'b11; req = 2'b10;
      tick();
      @(negedge clk);
      total_cnt++; if (gnt !== 2'b10) $display("FAIL to_grant: got %b want 10", gnt); else pass_cnt++;
      early = 0;
      for (int i = 1; i <= 15; i++) begin
         tick(); @(negedge clk);
         if (tevt !== 1'b0 || gnt !== 2'b10) early = 1;
      end
      total_cnt++; if (early) $display("FAIL to_early: revoked before cycle %0d, want none", T); else pass_cnt++;
      tick(); @(negedge clk);
      total_cnt++; if ({tevt, gnt} !== 3'b100) $display("FAIL to_event: got %b want 100", {tevt, gnt}); else pass_cnt++;
      tick(); @(negedge clk);
      total_cnt++; if (tevt !== 1'b0) $display("FAIL to_pulse_len: got %b want 0", tevt); else pass_cnt++;
      regrant = 0;
      for (int i = 0; i < 12; i++) begin
         tick(); @(negedge clk);
         if (gnt !== 2'b00) regrant = 1;
      end
      total_cnt++; if (regrant) $display("FAIL to_masked: got regrant want none"); else pass_cnt++;
      req = 2'b00; tick(); req = 2'b10;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(); @(negedge clk);
         if (gnt === 2'b10) got = 1;
      end
      total_cnt++; if (!got) $display("FAIL to_unmask: got %b want 10", gnt); else pass_cnt++;
   endtask

   task automatic test_progress();
      bit seen;
      do_reset();
      req = 2'b01;
      tick();
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         mcu = (i % 10 == 9);
         tick(); @(negedge clk);
         if (tevt !== 1'b0) seen = 1;
      end
      mcu = 1'b0;
      total_cnt++; if (seen || gnt !== 2'b01)
         $display("FAIL progress: tevt_seen=%0d gnt=%b want 0/01", seen, gnt); else pass_cnt++;
      rel = 2'b01; tick(); rel = 2'b00; req = 2'b00;
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_release_at_threshold();
      bit got;
      do_reset();
      req = 2'b01;
      tick();
      for (int i = 1; i <= 15; i++) tick();
      rel = 2'b01;
      tick();
      rel = 2'b00;
      @(negedge clk);
      total_cnt++; if ({tevt, gnt} !== 3'b000) $display("FAIL thr_release: got %b want 000", {tevt, gnt}); else pass_cnt++;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(); @(negedge clk);
         if (gnt !== 2'b00) got = 1;
      end
      total_cnt++; if (gnt !== 2'b01) $display("FAIL thr_not_masked: got %b want 01", gnt); else pass_cnt++;
   endtask

   task automatic test_reset_mid_own();
      do_reset();
      req = 2'b10; rnsel = 2'b01; rdo = 2'b01;
      tick(); @(negedge clk);
      total_cnt++; if ({gnt, nsel, sdo} !== 4'b1000) $display("FAIL rst_own: got %b want 1000", {gnt, nsel, sdo}); else pass_cnt++;
      rst = 1'b1;
      tick(); @(negedge clk);
      total_cnt++; if ({gnt, nsel, sdo} !== 4'b0011) $display("FAIL rst_mid: got %b want 0011", {gnt, nsel, sdo}); else pass_cnt++;
      rst = 1'b0; req = 2'b11;
      tick(); @(negedge clk);
      total_cnt++; if (gnt !== 2'b01) $display("FAIL rst_regrant: got %b want 01", gnt); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [1:0] e_gnt;
      logic [7:0] e_vec, a_vec;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
            rel[b] = ($urandom_range(0, 19) == 0);
         end
         mcu   = ($urandom_range(0, 24) == 0);
         rdo   = 2'($urandom); rnsel = 2'($urandom);
         rrun  = 2'($urandom); rstr  = 2'($urandom);
         @(negedge clk);
         e_gnt = (m_own < 0) ? 2'b00 : ((m_own == 1) ? 2'b10 : 2'b01);
         if (m_own >= 0)
            e_vec = {e_gnt, rdo[m_own], rnsel[m_own], rrun[m_own], rstr[m_own], 1'b1, m_tevt};
         else
            e_vec = {e_gnt, 4'b1100, (m_guard > 0) || (req != 2'b00), m_tevt};
         a_vec = {gnt, sdo, nsel, run, str, busy, tevt};
         total_cnt++;
         if (a_vec !== e_vec) $display("FAIL random_cycle_%0d: got %b want %b", i, a_vec, e_vec);
         else pass_cnt++;
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_progress();
      test_release_at_threshold();
      test_reset_mid_own();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
